lane_vrf_write_stage: RTL and testbench

Final lane pipeline stage. It converts an executed element group into a VRF write request and buffers it in a parametrised FIFO until the VRF arbiter accepts it. It generalises the fixed 32-bit, depth-4 write stage: data width, FIFO depth and index width are parameters, the last flag is carried from the input, all-zero-mask beats are dropped, and a per-instruction pending vector is exported so the lane controller can tell when an instruction's writes have drained.

---
 rtl/lane_vrf_write_stage.sv | 137 +++++++++++++
 tb/tb_lane_vrf_write_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_vrf_write_stage.sv
// Final lane stage: maps an executed element group to a VRF write request and
// queues it in a small FIFO until the VRF arbiter takes it.
module lane_vrf_write_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int GROUP_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 4,
  parameter int VD_WIDTH     = 5,
  parameter int IDX_WIDTH    = 3,
  parameter int DEPTH        = 4,
  parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enqueue_valid,
  output logic                    enqueue_ready,
  input  logic [GROUP_WIDTH-1:0]  enqueue_bits_groupCounter,
  input  logic [DATA_WIDTH-1:0]   enqueue_bits_data,
  input  logic [MASK_WIDTH-1:0]   enqueue_bits_mask,
  input  logic                    enqueue_bits_last,
  input  logic [IDX_WIDTH-1:0]    enqueue_bits_instructionIndex,
  input  logic [VD_WIDTH-1:0]     enqueue_bits_vd,
  output logic                    vrfWriteRequest_valid,
  input  logic                    vrfWriteRequest_ready,
  output logic [VD_WIDTH-1:0]     vrfWriteRequest_bits_vd,
  output logic [OFFSET_WIDTH-1:0] vrfWriteRequest_bits_offset,
  output logic [MASK_WIDTH-1:0]   vrfWriteRequest_bits_mask,
  output logic [DATA_WIDTH-1:0]   vrfWriteRequest_bits_data,
  output logic                    vrfWriteRequest_bits_last,
  output logic [IDX_WIDTH-1:0]    vrfWriteRequest_bits_instructionIndex,
  output logic [CNT_WIDTH-1:0]    occupancy,
  output logic [(1<<IDX_WIDTH)-1:0] pendingInstr
);

  localparam int NUM_INSTR = 1 << IDX_WIDTH;
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  typedef struct packed {
    logic [VD_WIDTH-1:0]     vd;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [MASK_WIDTH-1:0]   mask;
    logic [DATA_WIDTH-1:0]   data;
    logic                    last;
    logic [IDX_WIDTH-1:0]    idx;
  } entry_t;

  entry_t                 mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_WIDTH-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_WIDTH-1:0]   occ_q, occ_d;
  logic [CNT_WIDTH-1:0]   pendCnt_q [NUM_INSTR];
  logic [CNT_WIDTH-1:0]   pendCnt_d [NUM_INSTR];
  logic [NUM_INSTR-1:0]   incVec, decVec;

  logic   droppable, full, push, pop;
  entry_t newEntry, headEntry;

  // Upper group bits step through consecutive registers; the sum wraps.
  assign newEntry.vd     = enqueue_bits_vd
                         + VD_WIDTH'(enqueue_bits_groupCounter[GROUP_WIDTH-1:OFFSET_WIDTH]);
  assign newEntry.offset = enqueue_bits_groupCounter[OFFSET_WIDTH-1:0];
  assign newEntry.mask   = enqueue_bits_mask;
  assign newEntry.data   = enqueue_bits_data;
  assign newEntry.last   = enqueue_bits_last;
  assign newEntry.idx    = enqueue_bits_instructionIndex;

  assign droppable     = (enqueue_bits_mask == '0) & ~enqueue_bits_last;
  assign full          = (occ_q == DEPTH_C);
  assign enqueue_ready = ~full | droppable;
  assign push          = enqueue_valid & enqueue_ready & ~droppable;
  assign pop           = vrfWriteRequest_valid & vrfWriteRequest_ready;

  assign headEntry                             = mem_q[rdPtr_q];
  assign vrfWriteRequest_valid                 = (occ_q != '0);
  assign vrfWriteRequest_bits_vd               = headEntry.vd;
  assign vrfWriteRequest_bits_offset           = headEntry.offset;
  assign vrfWriteRequest_bits_mask             = headEntry.mask;
  assign vrfWriteRequest_bits_data             = headEntry.data;
  assign vrfWriteRequest_bits_last             = headEntry.last;
  assign vrfWriteRequest_bits_instructionIndex = headEntry.idx;
  assign occupancy                             = occ_q;

  always_comb begin
    wrPtr_d = push ? wrPtr_q + PTR_WIDTH'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + PTR_WIDTH'(1) : rdPtr_q;
    occ_d   = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CNT_WIDTH'(1);
      2'b01:   occ_d = occ_q - CNT_WIDTH'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    incVec = '0;
    decVec = '0;
    if (push) incVec[enqueue_bits_instructionIndex] = 1'b1;
    if (pop)  decVec[headEntry.idx] = 1'b1;
  end

  // A push and pop on the same index cancel out.
  always_comb begin
    for (int i = 0; i < NUM_INSTR; i++) begin
      pendCnt_d[i] = pendCnt_q[i];
      if (incVec[i] & ~decVec[i])      pendCnt_d[i] = pendCnt_q[i] + CNT_WIDTH'(1);
      else if (decVec[i] & ~incVec[i]) pendCnt_d[i] = pendCnt_q[i] - CNT_WIDTH'(1);
      pendingInstr[i] = (pendCnt_q[i] != '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < NUM_INSTR; i++) pendCnt_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      occ_q   <= occ_d;
      for (int i = 0; i < NUM_INSTR; i++) pendCnt_q[i] <= pendCnt_d[i];
    end
  end

  // Payload storage carries no reset; it is only observed while valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wrPtr_q] <= newEntry;
  end

  for (genvar g = 0; g < NUM_INSTR; g++) begin : gPendChk
    assert property (@(posedge clock) disable iff (reset) pendCnt_q[g] <= DEPTH_C);
    assert property (@(posedge clock) disable iff (reset)
                     !(decVec[g] && !incVec[g] && pendCnt_q[g] == '0));
  end

endmodule

// File: tb/tb_lane_vrf_write_stage.sv
// Self-checking bench for lane_vrf_write_stage: directed table, corner sequences
// and random traffic against a queue-based reference model.
module tb_lane_vrf_write_stage;

  localparam int DW = 32;
  localparam int MW = 4;
  localparam int GW = 8;
  localparam int OW = 4;
  localparam int VW = 5;
  localparam int IW = 3;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enqValid = 1'b0;
  logic          enqReady;
  logic [GW-1:0] enqGc = '0;
  logic [DW-1:0] enqData = '0;
  logic [MW-1:0] enqMask = '0;
  logic          enqLast = 1'b0;
  logic [IW-1:0] enqIdx = '0;
  logic [VW-1:0] enqVd = '0;
  logic          reqValid;
  logic          reqReady = 1'b0;
  logic [VW-1:0] reqVd;
  logic [OW-1:0] reqOffset;
  logic [MW-1:0] reqMask;
  logic [DW-1:0] reqData;
  logic          reqLast;
  logic [IW-1:0] reqIdx;
  logic [CW-1:0] occupancy;
  logic [7:0]    pendingInstr;

  lane_vrf_write_stage dut (
    .clock(clock), .reset(reset),
    .enqueue_valid(enqValid), .enqueue_ready(enqReady),
    .enqueue_bits_groupCounter(enqGc), .enqueue_bits_data(enqData),
    .enqueue_bits_mask(enqMask), .enqueue_bits_last(enqLast),
    .enqueue_bits_instructionIndex(enqIdx), .enqueue_bits_vd(enqVd),
    .vrfWriteRequest_valid(reqValid), .vrfWriteRequest_ready(reqReady),
    .vrfWriteRequest_bits_vd(reqVd), .vrfWriteRequest_bits_offset(reqOffset),
    .vrfWriteRequest_bits_mask(reqMask), .vrfWriteRequest_bits_data(reqData),
    .vrfWriteRequest_bits_last(reqLast),
    .vrfWriteRequest_bits_instructionIndex(reqIdx),
    .occupancy(occupancy), .pendingInstr(pendingInstr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [VW-1:0] vd;
    logic [OW-1:0] off;
    logic [MW-1:0] mask;
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] idx;
  } entry_t;

  typedef struct {
    logic          ev;
    logic [GW-1:0] gc;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic          last;
    logic [IW-1:0] idx;
    logic [VW-1:0] vd;
    logic          vr;
    logic          expReady;
    logic          expValid;
    logic [CW-1:0] expOcc;
    logic [7:0]    expPend;
    logic [VW-1:0] expVd;
    logic [OW-1:0] expOff;
    logic [DW-1:0] expData;
  } vector_t;

  entry_t  modelQ[$];
  vector_t vecs[12];
  int      checks = 0;
  int      fails = 0;

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] modelPending();
    logic [7:0] p = '0;
    foreach (modelQ[k]) p[modelQ[k].idx] = 1'b1;
    return p;
  endfunction

  function automatic logic modelDroppable();
    return (enqMask == '0) && !enqLast;
  endfunction

  // Compare every DUT output with what the reference model predicts right now.
  task automatic checkOutput();
    logic expRdy;
    expRdy = (modelQ.size() < DEPTH) || modelDroppable();
    checkValue("enqueue_ready", enqReady, expRdy);
    checkValue("valid", reqValid, modelQ.size() != 0);
    checkValue("occupancy", occupancy, modelQ.size());
    checkValue("pendingInstr", pendingInstr, modelPending());
    if (modelQ.size() != 0) begin
      checkValue("bits_vd", reqVd, modelQ[0].vd);
      checkValue("bits_offset", reqOffset, modelQ[0].off);
      checkValue("bits_mask", reqMask, modelQ[0].mask);
      checkValue("bits_data", reqData, modelQ[0].data);
      checkValue("bits_last", reqLast, modelQ[0].last);
      checkValue("bits_idx", reqIdx, modelQ[0].idx);
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic [GW-1:0] gc, input logic [DW-1:0] data,
                               input logic [MW-1:0] mask, input logic last, input logic [IW-1:0] idx,
                               input logic [VW-1:0] vd, input logic vr, output logic rdyBefore);
    entry_t e;
    logic   drop, rdy;
    @(negedge clock);
    enqValid = ev; enqGc = gc; enqData = data; enqMask = mask;
    enqLast = last; enqIdx = idx; enqVd = vd; reqReady = vr;
    #1;
    checkOutput();
    rdyBefore = enqReady;
    @(posedge clock);
    drop = modelDroppable();
    rdy  = (modelQ.size() < DEPTH) || drop;
    if (modelQ.size() != 0 && vr) void'(modelQ.pop_front());
    if (ev && rdy && !drop) begin
      e.vd   = VW'((int'(vd) + int'(gc) / 16) % 32);
      e.off  = OW'(int'(gc) % 16);
      e.mask = mask;
      e.data = data;
      e.last = last;
      e.idx  = idx;
      modelQ.push_back(e);
    end
  endtask

  initial begin
    logic       r;
    logic [7:0] drainExp [3];

    vecs[0]  = '{1, 8'h25, 32'hDEADBEEF, 4'hF, 0, 3'd2, 5'd3,  0, 1, 1, 3'd1, 8'h04, 5'd5, 4'd5, 32'hDEADBEEF};
    vecs[1]  = '{1, 8'h30, 32'h11111111, 4'hF, 0, 3'd3, 5'd30, 0, 1, 1, 3'd2, 8'h0C, 5'd5, 4'd5, 32'hDEADBEEF};
    vecs[2]  = '{1, 8'h01, 32'h22222222, 4'h3, 0, 3'd0, 5'd0,  0, 1, 1, 3'd3, 8'h0D, 5'd5, 4'd5, 32'hDEADBEEF};
    vecs[3]  = '{1, 8'h02, 32'h33333333, 4'h1, 0, 3'd0, 5'd1,  0, 1, 1, 3'd4, 8'h0D, 5'd5, 4'd5, 32'hDEADBEEF};
    vecs[4]  = '{1, 8'h03, 32'h55555555, 4'h0, 0, 3'd5, 5'd7,  0, 1, 1, 3'd4, 8'h0D, 5'd5, 4'd5, 32'hDEADBEEF};
    vecs[5]  = '{1, 8'h04, 32'h44444444, 4'h0, 1, 3'd5, 5'd2,  0, 0, 1, 3'd4, 8'h0D, 5'd5, 4'd5, 32'hDEADBEEF};
    vecs[6]  = '{1, 8'h04, 32'h44444444, 4'h0, 1, 3'd5, 5'd2,  1, 0, 1, 3'd3, 8'h09, 5'd1, 4'd0, 32'h11111111};
    vecs[7]  = '{1, 8'h04, 32'h44444444, 4'h0, 1, 3'd5, 5'd2,  0, 1, 1, 3'd4, 8'h29, 5'd1, 4'd0, 32'h11111111};
    vecs[8]  = '{0, 8'h00, 32'h0,        4'h0, 0, 3'd0, 5'd0,  1, 1, 1, 3'd3, 8'h21, 5'd0, 4'd1, 32'h22222222};
    vecs[9]  = '{0, 8'h00, 32'h0,        4'h0, 0, 3'd0, 5'd0,  1, 1, 1, 3'd2, 8'h21, 5'd1, 4'd2, 32'h33333333};
    vecs[10] = '{0, 8'h00, 32'h0,        4'h0, 0, 3'd0, 5'd0,  1, 1, 1, 3'd1, 8'h20, 5'd2, 4'd4, 32'h44444444};
    vecs[11] = '{0, 8'h00, 32'h0,        4'h0, 0, 3'd0, 5'd0,  1, 1, 0, 3'd0, 8'h00, 5'd0, 4'd0, 32'h0};
    drainExp = '{8'h42, 8'h40, 8'h00};

    #12;
    checkValue("reset_valid", reqValid, 1'b0);
    checkValue("reset_occupancy", occupancy, 0);
    checkValue("reset_pending", pendingInstr, 8'h00);
    checkValue("reset_ready", enqReady, 1'b1);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] directed table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].ev, vecs[i].gc, vecs[i].data, vecs[i].mask, vecs[i].last,
                    vecs[i].idx, vecs[i].vd, vecs[i].vr, r);
      #1;
      checkValue($sformatf("tbl%0d_ready", i), r, vecs[i].expReady);
      checkValue($sformatf("tbl%0d_valid", i), reqValid, vecs[i].expValid);
      checkValue($sformatf("tbl%0d_occ", i), occupancy, vecs[i].expOcc);
      checkValue($sformatf("tbl%0d_pend", i), pendingInstr, vecs[i].expPend);
      if (vecs[i].expValid) begin
        checkValue($sformatf("tbl%0d_vd", i), reqVd, vecs[i].expVd);
        checkValue($sformatf("tbl%0d_off", i), reqOffset, vecs[i].expOff);
        checkValue($sformatf("tbl%0d_data", i), reqData, vecs[i].expData);
      end
    end

    $display("[TB] simultaneous push/pop at occupancy 2");
    applyStimulus(1, 8'h10, 32'hA0000001, 4'hF, 0, 3'd4, 5'd0, 0, r);
    applyStimulus(1, 8'h11, 32'hA0000002, 4'hF, 0, 3'd4, 5'd0, 0, r);
    for (int i = 3; i <= 5; i++) begin
      applyStimulus(1, GW'(8'h10 + i), DW'(32'hA0000000 + i), 4'hF, 0, 3'd4, 5'd0, 1, r);
      #1;
      checkValue("pushpop_occ", occupancy, 2);
      checkValue("pushpop_pend", pendingInstr, 8'h10);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, r);

    $display("[TB] drain tracking");
    applyStimulus(1, 8'h00, 32'hB0000001, 4'hF, 0, 3'd1, 5'd8, 0, r);
    applyStimulus(1, 8'h01, 32'hB0000002, 4'hF, 0, 3'd1, 5'd8, 0, r);
    applyStimulus(1, 8'h02, 32'hB0000003, 4'hF, 1, 3'd6, 5'd8, 0, r);
    #1;
    checkValue("drain_pend0", pendingInstr, 8'h42);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, r);
      #1;
      checkValue($sformatf("drain_pend%0d", i + 1), pendingInstr, drainExp[i]);
      if (i == 1) checkValue("drain_last", reqLast, 1'b1);
    end

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(1, 8'h05, 32'hC0000001, 4'hF, 0, 3'd0, 5'd1, 0, r);
    applyStimulus(1, 8'h06, 32'hC0000002, 4'hF, 0, 3'd2, 5'd1, 0, r);
    applyStimulus(1, 8'h07, 32'hC0000003, 4'hF, 0, 3'd7, 5'd1, 0, r);
    @(negedge clock);
    enqValid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkValue("arst_valid", reqValid, 1'b0);
    checkValue("arst_occ", occupancy, 0);
    checkValue("arst_pend", pendingInstr, 8'h00);
    checkValue("arst_ready", enqReady, 1'b1);
    modelQ.delete();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1, 8'h52, 32'hCAFEF00D, 4'h6, 0, 3'd3, 5'd10, 0, r);
    #1;
    checkValue("postrst_valid", reqValid, 1'b1);
    checkValue("postrst_vd", reqVd, 5'd15);
    checkValue("postrst_off", reqOffset, 4'd2);
    checkValue("postrst_data", reqData, 32'hCAFEF00D);
    checkValue("postrst_pend", pendingInstr, 8'h08);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [MW-1:0] m;
      m = ($urandom_range(0, 3) == 0) ? '0 : MW'($urandom);
      applyStimulus(1'($urandom), GW'($urandom), $urandom, m, ($urandom_range(0, 3) == 0),
                    IW'($urandom), VW'($urandom), ($urandom_range(0, 2) != 0), r);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, r);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
